// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned WORD_BYTES   = 4;
  localparam logic [31:0] WRCOUNT_ADDR = 32'hFFFFFFFC;
  localparam int unsigned WAIT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, single shared address.
module dmem_array #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES extra cycles, one-cycle ready.
// Optional committed-write counter readable at WRCOUNT_ADDR when DMEM_WRCOUNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam logic [WAIT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_W'(WAIT_STATES - 1);

  state_t            state, next;
  logic [WAIT_W-1:0] cnt, cnt_next;
  logic              cap;
  logic              req_err, req_sel;
  logic              wr_q, err_q, sel_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              cur_wr, cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       cur_wdata;
  logic              enter_resp, we;
  logic [31:0]       rdata, wrcount;

  // Request classification from live inputs (only meaningful at capture).
  always_comb begin
    req_err = (dataadr[1:0] != 2'b00) || (memread && memwrite) ||
              (dataadr[31:ADDR_W+2] != '0);
    req_sel = 1'b0;
`ifdef DMEM_WRCOUNT_EN
    if (dataadr == WRCOUNT_ADDR) begin
      req_sel = memread && !memwrite;
      req_err = !req_sel;
    end
`endif
  end

  always_comb begin
    next     = state;
    cnt_next = cnt;
    cap      = 1'b0;
    case (state)
      IDLE: if (memread || memwrite) begin
        cap = 1'b1;
        if (WAIT_STATES == 0) next = RESP;
        else begin
          next     = WAIT;
          cnt_next = WS_LOAD;
        end
      end
      WAIT: if (cnt == '0) next = RESP;
            else cnt_next = cnt - 1'b1;
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the capture edge, so the
  // request must come straight from the inputs rather than the latches.
  always_comb begin
    cur_wr    = (state == IDLE) ? memwrite  : wr_q;
    cur_err   = (state == IDLE) ? req_err   : err_q;
    cur_idx   = (state == IDLE) ? dataadr[ADDR_W+1:2] : idx_q;
    cur_wdata = (state == IDLE) ? writedata : wdata_q;
  end

  assign enter_resp = (next == RESP) && (state != RESP) && !reset;
  assign we         = enter_resp && cur_wr && !cur_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= next;
      cnt   <= cnt_next;
      if (cap) begin
        wr_q    <= memwrite;
        err_q   <= req_err;
        sel_q   <= req_sel;
        idx_q   <= dataadr[ADDR_W+1:2];
        wdata_q <= writedata;
      end
    end
  end

`ifdef DMEM_WRCOUNT_EN
  always_ff @(posedge clk) begin
    if (reset) wrcount <= '0;
    else if (we && (wrcount != '1)) wrcount <= wrcount + 32'd1;
  end
`else
  assign wrcount = '0;
`endif

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (we),
    .re    (enter_resp),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

  assign ready    = (state == RESP);
  assign err      = ready && err_q;
  assign readdata = (ready && !err_q) ? (sel_q ? wrcount : rdata) : '0;

endmodule
